vmem_port_arbiter: RTL and testbench
====================================

# vmem_port_arbiter

Shares the single synchronous port of the 16K×12 video memory between the video generator's scanline fetch and a CPU-side requester. Video fetch has absolute priority and is passed through combinationally with zero added latency. CPU reads and writes are serviced in cycles where video does not need the port, using a req/ack handshake. The block sits between the video generator, the CPU bus bridge and the video RAM.

## Interface
- ADDR_W, 14, video memory address width
- DATA_W, 12, video memory word width

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- vid_req  in  1  video needs the port this cycle (even scanline, vga_x ≤ 256)
- vid_addr  in  ADDR_W  video fetch address
- vid_rdata  out  DATA_W  = mem_rdata, unregistered
- cpu_req  in  1  CPU request; held with addr/we/wdata until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data; valid in the ack cycle, held until the next read ack
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM output; valid the cycle after its address

## Operation
- FSM states: IDLE, RD_WAIT, RD_ACK, WR_ACK.
- Port mux, combinational: vid_req=1 → mem_addr=vid_addr, mem_we=0. Otherwise the CPU is granted when state=IDLE and cpu_req=1: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata. All other cycles: mem_addr=vid_addr, mem_we=0.
- IDLE: a grant with cpu_we=0 moves to RD_WAIT; a grant with cpu_we=1 moves to WR_ACK. If vid_req=1, stay in IDLE; the request waits with no timeout.
- RD_WAIT: capture mem_rdata into the cpu_rdata register → RD_ACK. This happens regardless of vid_req, because mem_rdata still reflects the CPU address.
- RD_ACK: cpu_ack=1 → IDLE.
- WR_ACK: cpu_ack=1 → IDLE.
- cpu_req is re-sampled only in IDLE. The requester must drop it in the ack cycle or it is taken as a new request in the following cycle.
- Reset mid-operation: FSM → IDLE, cpu_ack=0. An in-flight read is abandoned. A write already strobed stays written.

## Timing
- Reset values: cpu_ack=0, cpu_rdata=0, mem_we=0 (mem_we is gated by rst while rst is high), FSM=IDLE, write buffer empty.
- Video path: zero latency; vid_rdata is valid the cycle after vid_addr. This is unchanged from a direct RAM connection.
- Read latency: grant cycle G; cpu_ack in G+2.
- Write latency: grant cycle G (RAM write at G); cpu_ack in G+1.
- Worst-case CPU wait: the 257-cycle video fetch window plus one cycle.
- Back-to-back throughput with no video traffic: 1 read per 3 cycles, 1 write per 2 cycles.

## Configuration
- VMEM_ARB_POSTED_WR_EN defined: a 1-entry posted write buffer is added.
  - A CPU write in IDLE with the buffer empty is accepted without the port and acked the next cycle.
  - The buffer drains on the first cycle with vid_req=0 and the FSM in IDLE. The drain has priority over a new CPU grant.
  - Any CPU request arriving while the buffer is full waits in IDLE until the drain. This preserves read-after-write ordering.
  - Reset empties the buffer; its contents are lost.
- VMEM_ARB_POSTED_WR_EN undefined: no buffer; writes behave exactly as in Operation.

## Structure
- Package vmem_arb_pkg holds:
  - the FSM state enum;
  - VMEM_ADDR_W=14 and VMEM_DATA_W=12 as parameter defaults;
  - the palette/mode address constants shared with the video generator (14'o30000 region).
- Sub-module vmem_wr_buffer, instantiated only under VMEM_ARB_POSTED_WR_EN:
  - contents: full flag, address and data registers;
  - ports: push, drain, full.

## Test plan
- Idle video, CPU read addr 0x0123 with RAM word 0xABC → mem_addr=0x0123 at G, cpu_ack at G+2 with cpu_rdata=0xABC; vid_rdata unaffected.
- CPU write 0x3FFF←0x5A5 while vid_req=1 for 10 cycles → no mem_we during the window; mem_we=1 with addr 0x3FFF in the first cycle vid_req=0; ack one cycle later.
- vid_req rises in RD_WAIT → video gets the port immediately; cpu_rdata still equals the CPU word and ack arrives at G+2.
- Assert rst in RD_WAIT → cpu_ack never pulses, cpu_rdata=0, FSM IDLE; a new read after release completes normally.
- cpu_req held high through ack → a second access is granted in the cycle after ack (two acks for one held request).
- With VMEM_ARB_POSTED_WR_EN:
  - write 0x0010←0x111 during a video window → ack next cycle; RAM is updated on the first free cycle;
  - immediate read of 0x0010 → returns 0x111 only after the drain.

Source files
------------

// File: rtl/vmem_arb_pkg.sv
// Shared types and constants for the video-memory port arbiter and the video generator.
package vmem_arb_pkg;

    localparam int VMEM_ADDR_W = 14;
    localparam int VMEM_DATA_W = 12;

    // Palette and mode registers live in the 14'o30000 region of video memory
    localparam logic [13:0] VMEM_PAL_BASE    = 14'o30000;
    localparam int          VMEM_PAL_ENTRIES = 16;
    localparam logic [13:0] VMEM_MODE_ADDR   = 14'o30020;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_ACK  = 2'd2,
        WR_ACK  = 2'd3
    } arb_state_e;

    function automatic logic is_palette_addr(input logic [13:0] addr);
        return addr[13:4] == VMEM_PAL_BASE[13:4];
    endfunction

endpackage

// File: rtl/vmem_wr_buffer.sv
// Single-entry posted write buffer; holds one CPU write until the RAM port is free.
module vmem_wr_buffer
    import vmem_arb_pkg::*;
#(
    parameter int ADDR_W = VMEM_ADDR_W,
    parameter int DATA_W = VMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              drain,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (push) begin
            full <= 1'b1;
            addr <= push_addr;
            data <= push_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/vmem_port_arbiter.sv
// Shares the video RAM port: video fetch wins combinationally, CPU gets req/ack access in free cycles.
// Define VMEM_ARB_POSTED_WR_EN to add a one-entry posted write buffer.
module vmem_port_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int ADDR_W = VMEM_ADDR_W,
    parameter int DATA_W = VMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state, state_nxt;
    logic              idle;
    logic              cpu_grant;
    logic              wr_push;
    logic              buf_drain;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              mem_we_raw;

    assign idle      = (state == IDLE);
    assign vid_rdata = mem_rdata;

`ifdef VMEM_ARB_POSTED_WR_EN
    logic buf_full;

    // Writes go to the buffer without the port; everything else waits while it is full
    assign buf_drain = buf_full && idle && !vid_req;
    assign wr_push   = idle && cpu_req && cpu_we && !buf_full;
    assign cpu_grant = idle && cpu_req && !cpu_we && !buf_full && !vid_req;

    vmem_wr_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_push),
        .push_addr (cpu_addr),
        .push_data (cpu_wdata),
        .drain     (buf_drain),
        .full      (buf_full),
        .addr      (buf_addr),
        .data      (buf_data)
    );
`else
    assign buf_drain = 1'b0;
    assign buf_addr  = '0;
    assign buf_data  = '0;
    assign wr_push   = 1'b0;
    assign cpu_grant = idle && cpu_req && !vid_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_grant || wr_push) state_nxt = cpu_we ? WR_ACK : RD_WAIT;
            RD_WAIT: state_nxt = RD_ACK;
            RD_ACK:  state_nxt = IDLE;
            WR_ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr   = vid_addr;
        mem_wdata  = cpu_wdata;
        mem_we_raw = 1'b0;
        cpu_ack    = (state == RD_ACK) || (state == WR_ACK);
        if (buf_drain) begin
            mem_addr   = buf_addr;
            mem_wdata  = buf_data;
            mem_we_raw = 1'b1;
        end else if (cpu_grant) begin
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
            mem_we_raw = cpu_we;
        end
    end

    // Keep the RAM from being strobed while reset is asserted
    assign mem_we = mem_we_raw && !rst;

    // RAM output in RD_WAIT still belongs to the CPU address, even if video took the port
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cpu_rdata <= '0;
        else if (state == RD_WAIT)  cpu_rdata <= mem_rdata;
    end

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Randomized scoreboard bench for vmem_port_arbiter against a RAM model and a precomputed video schedule.
module tb_vmem_port_arbiter;

    localparam int AW     = 14;
    localparam int DW     = 12;
    localparam int NCYC   = 12000;
    localparam int LONG_T = 6000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_rdata;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    vmem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit vid_sched [NCYC];

    function automatic bit vid_at(input int c);
        return (c >= 0 && c < NCYC) ? vid_sched[c] : 1'b0;
    endfunction

    function automatic int first_free(input int t);
        int c = t;
        while (vid_at(c)) c++;
        return c;
    endfunction

    typedef struct { bit we; logic [DW-1:0] data; int ack_cyc; } exp_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    exp_t sb_q[$];
    wr_t  wr_q[$];

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Video driver: follows the precomputed schedule so latency can be predicted
    initial begin
        forever begin
            @(posedge clk);
            #1;
            vid_req  = vid_at(cyc);
            vid_addr = AW'($urandom);
        end
    end

    // Monitor: pops expectations whenever the DUT strobes the RAM or acks the CPU
    always @(negedge clk) begin
        if (vid_req) begin
            check("vid_mux_addr", 32'(mem_addr), 32'(vid_addr));
            check("vid_mux_we", 32'(mem_we), 32'd0);
        end
        if (!rst && cyc > 5) check("vid_rdata", 32'(vid_rdata), 32'(mem_rdata));
        if (mem_we) begin
            if (wr_q.size() == 0) fail("unexpected_write");
            else begin
                wr_t w;
                w = wr_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(w.a));
                check("wr_data", 32'(mem_wdata), 32'(w.d));
            end
        end
        if (cpu_ack) begin
            if (sb_q.size() == 0) fail("unexpected_ack");
            else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.ack_cyc >= 0) check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                if (!e.we) begin
                    check("rd_data", 32'(cpu_rdata), 32'(e.data));
                    last_rd = e.data;
                end else begin
                    check("rdata_hold", 32'(cpu_rdata), 32'(last_rd));
                end
            end
        end
        if (rst) begin
            check("rst_ack", 32'(cpu_ack), 32'd0);
            check("rst_rdata", 32'(cpu_rdata), 32'd0);
            check("rst_we", 32'(mem_we), 32'd0);
            last_rd = '0;
        end
    end

    // One CPU request held for 'reps' acks; expectations are derived from the video schedule
    task automatic access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int reps);
        int t, g, acks, budget;
        exp_t e;
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        t = cyc;
        for (int r = 0; r < reps; r++) begin
            g = first_free(t);
            e.we = we;
            e.data = we ? '0 : ref_mem[a];
`ifdef VMEM_ARB_POSTED_WR_EN
            e.ack_cyc = -1;
`else
            e.ack_cyc = we ? g + 1 : g + 2;
`endif
            sb_q.push_back(e);
            if (we) begin
                ref_mem[a] = d;
                wr_q.push_back('{a: a, d: d});
            end
            t = (we ? g + 1 : g + 2) + 1;
        end
        acks = 0;
        budget = 2000;
        while (acks < reps && budget > 0) begin
            @(negedge clk);
            if (cpu_ack) acks++;
            budget--;
        end
        if (acks < reps) fail("ack_timeout");
        cpu_req = 1'b0;
    endtask

    task automatic wait_drained();
        int budget = 2000;
        while ((wr_q.size() != 0 || sb_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
    endtask

    task automatic random_txn();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) a = a | 14'h3FF8;
        access(1'($urandom_range(0, 1)), a, DW'($urandom),
               ($urandom_range(0, 7) == 0) ? 2 : 1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    initial begin
        int c, on, off, t, g;
        logic [DW-1:0] v;
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            ram[i] <= v;
            ref_mem[i] = v;
        end
        ram[14'h0123] <= 12'hABC;
        ref_mem[14'h0123] = 12'hABC;
        c = 30;
        while (c < NCYC) begin
            on  = $urandom_range(0, 12);
            off = $urandom_range(1, 8);
            for (int k = 0; k < on && c < NCYC; k++) begin vid_sched[c] = 1'b1; c++; end
            for (int k = 0; k < off && c < NCYC; k++) begin vid_sched[c] = 1'b0; c++; end
        end
        for (int k = LONG_T; k < LONG_T + 257; k++) vid_sched[k] = 1'b1;
        vid_sched[LONG_T + 257] = 1'b0;

        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        access(1'b0, 14'h0123, '0, 1);
        for (int n = 0; n < 100; n++) random_txn();

        // Write issued at the start of the full-length fetch window
        while (cyc < LONG_T - 1) @(posedge clk);
        access(1'b1, 14'h3FFF, 12'h5A5, 1);
        access(1'b0, 14'h3FFF, '0, 1);

        // Reset while a read is in RD_WAIT
        wait_drained();
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        t = cyc;
        g = first_free(t);
        while (cyc < g + 1) begin @(posedge clk); #1; end
        rst = 1'b1;
        cpu_we = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'b0; rst = 1'b0;
        repeat (4) @(posedge clk);
        access(1'b0, 14'h0123, '0, 1);

        for (int n = 0; n < 50; n++) random_txn();

        wait_drained();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog at cycle %0d", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
